// File: rtl/mp_adder_pkg.sv
// Shared types and defaults for the word-serial multi-precision adder.
package mp_adder_pkg;

    localparam int N_DEF     = 32;
    localparam int WORDS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Index of the most-significant word of an operand.
    function automatic int last_idx(input int words);
        return words - 1;
    endfunction

endpackage

// File: rtl/cla_word_adder.sv
// N-bit adder made of N/4 chained 4-bit carry-lookahead slices.
module cla_word_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    localparam int SLICES = N / 4;

    logic [SLICES:0] slice_c;

    assign slice_c[0] = carry_in;

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;

        assign g = a[4*s +: 4] & b[4*s +: 4];
        assign p = a[4*s +: 4] ^ b[4*s +: 4];

        // Carries inside a slice are fully expanded; slices ripple into each other.
        assign c[0] = slice_c[s];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);
        assign slice_c[s+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                            | (p[3] & p[2] & p[1] & g[0])
                            | (p[3] & p[2] & p[1] & p[0] & c[0]);

        assign sum[4*s +: 4] = p ^ c;
    end

    assign carry_out = slice_c[SLICES];

endmodule

// File: rtl/mp_adder_seq.sv
// Word-serial multi-precision adder, LS word first, valid/ready on both sides.
// Optional subtraction (A-B) is enabled by defining MP_ADDER_SEQ_SUB_EN.
module mp_adder_seq
    import mp_adder_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WORDS = WORDS_DEF,
    parameter int CNT_W = $clog2(WORDS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_word,
    input  logic [N-1:0] b_word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s_word,
    output logic         out_last,
    output logic         carry_out,
    output logic         busy,
    output logic         done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(last_idx(WORDS));

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic             accept;
    logic [N-1:0]     b_eff;
    logic             cin;
    logic [N-1:0]     sum;
    logic             sum_carry;

`ifdef MP_ADDER_SEQ_SUB_EN
    logic sub_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_mode <= 1'b0;
        end else if (state == IDLE && start) begin
            sub_mode <= sub;
        end
    end

    // Two's-complement subtraction: invert B and seed the carry chain with 1.
    assign b_eff = sub_mode ? ~b_word : b_word;
    assign cin   = sub;
`else
    logic unused_sub;

    assign unused_sub = sub;
    assign b_eff      = b_word;
    assign cin        = 1'b0;
`endif

    cla_word_adder #(.N(N)) u_adder (
        .a         (a_word),
        .b         (b_eff),
        .carry_in  (carry_q),
        .sum       (sum),
        .carry_out (sum_carry)
    );

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
                if (accept && cnt == LAST) next_state = DRAIN;
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            carry_q   <= 1'b0;
            s_word    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        carry_q <= cin;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        s_word    <= sum;
                        carry_q   <= sum_carry;
                        out_valid <= 1'b1;
                        out_last  <= (cnt == LAST);
                        cnt       <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        carry_out <= carry_q;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_adder_seq.sv
// Scoreboard bench for mp_adder_seq (N=32, WORDS=4); covers SUB mode when MP_ADDER_SEQ_SUB_EN is defined.
module tb_mp_adder_seq;

    localparam int N     = 32;
    localparam int WORDS = 4;

    typedef struct {
        logic [N-1:0] w;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a_word = '0;
    logic [N-1:0] b_word = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] s_word;
    logic         out_last;
    logic         carry_out;
    logic         busy;
    logic         done;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    bit   mon_en = 1'b1;
    exp_t sb[$];

    mp_adder_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_word    (a_word),
        .b_word    (b_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_word    (s_word),
        .out_last  (out_last),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) done_cnt++;
            if (rst_n && mon_en && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", s_word, 64'hx);
                end else begin
                    e = sb.pop_front();
                    check("s_word", s_word, e.w);
                    check("out_last", out_last, e.last);
                end
            end
        end
    end

    task automatic run_op(input logic [4*N-1:0] a, input logic [4*N-1:0] b, input logic s,
                          input logic [4*N-1:0] exp_s, input logic exp_c,
                          input bit poke, input bit bp);
        int d0;
        int t;
        for (int i = 0; i < WORDS; i++) begin
            exp_t e;
            e.w    = exp_s[N*i +: N];
            e.last = (i == WORDS - 1);
            sb.push_back(e);
        end
        d0 = done_cnt;
        @(posedge clk) #1;
        if (bp) out_ready = 1'b0;
        start = 1'b1;
        sub   = s;
        @(posedge clk) #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        fork
            begin
                for (int i = 0; i < WORDS; i++) begin
                    in_valid = 1'b1;
                    a_word   = a[N*i +: N];
                    b_word   = b[N*i +: N];
                    start    = poke && (i == 1);
                    t = 0;
                    @(negedge clk);
                    while (!in_ready && t < 200) begin
                        @(negedge clk);
                        t++;
                    end
                    if (t >= 200) check("in_ready_timeout", 1'b0, 1'b1);
                    @(posedge clk) #1;
                    start = 1'b0;
                end
                in_valid = 1'b0;
            end
            begin
                if (bp) begin
                    int w = 0;
                    @(negedge clk);
                    while (!out_valid && w < 50) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 50) check("out_valid_timeout", 1'b0, 1'b1);
                    for (int k = 0; k < 3; k++) begin
                        if (k > 0) @(negedge clk);
                        check("bp_in_ready", in_ready, 1'b0);
                        check("bp_out_valid", out_valid, 1'b1);
                        check("bp_s_word_held", s_word, exp_s[N-1:0]);
                    end
                    @(posedge clk) #1;
                    out_ready = 1'b1;
                end
            end
        join
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("carry_out", carry_out, exp_c);
        check("busy_after_done", busy, 1'b0);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_s_word", s_word, 0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_carry_out", carry_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(posedge clk) #1;
        rst_n = 1'b1;

        // Carry ripples across three words, no final carry.
        run_op({32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
               {32'h0, 32'h0, 32'h0, 32'h1}, 1'b0,
               {32'h2, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0, 1'b0);

        // All-ones plus one: full-width overflow.
        run_op({4{32'hFFFFFFFF}}, {32'h0, 32'h0, 32'h0, 32'h1}, 1'b0,
               {4{32'h0}}, 1'b1, 1'b0, 1'b0);

        // Abort after two accepted words.
        mon_en = 1'b0;
        @(posedge clk) #1;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        in_valid = 1'b1;
        a_word = 32'h1;
        b_word = 32'h1;
        @(posedge clk) #1;
        a_word = 32'h2;
        @(posedge clk) #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_carry_out", carry_out, 1'b0);
        check("abort_in_ready", in_ready, 1'b0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        sb.delete();
        mon_en = 1'b1;

        // Backpressure on the first output word, fresh operation after the abort.
        run_op({32'h3, 32'h2, 32'h1, 32'h12345678},
               {32'h30, 32'h20, 32'h10, 32'h11111111}, 1'b0,
               {32'h33, 32'h22, 32'h11, 32'h23456789}, 1'b0, 1'b0, 1'b1);

        // start pulsed mid-operation must be ignored.
        run_op({4{32'hF0000000}}, {4{32'h10000000}}, 1'b0,
               {32'h1, 32'h1, 32'h1, 32'h0}, 1'b1, 1'b1, 1'b0);

`ifdef MP_ADDER_SEQ_SUB_EN
        // 5 - 7 borrows; 7 - 5 does not.
        run_op({32'h0, 32'h0, 32'h0, 32'h5}, {32'h0, 32'h0, 32'h0, 32'h7}, 1'b1,
               {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE}, 1'b0, 1'b0, 1'b0);
        run_op({32'h0, 32'h0, 32'h0, 32'h7}, {32'h0, 32'h0, 32'h0, 32'h5}, 1'b1,
               {32'h0, 32'h0, 32'h0, 32'h2}, 1'b1, 1'b0, 1'b0);
`else
        // sub is ignored: 5 + 7.
        run_op({32'h0, 32'h0, 32'h0, 32'h5}, {32'h0, 32'h0, 32'h0, 32'h7}, 1'b1,
               {32'h0, 32'h0, 32'h0, 32'hC}, 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
